// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer constants, types and fetch states
// for the framebuffer line prefetch / host write arbiter.
package vga_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 15;
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int COL_W      = $clog2(FB_W);

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;
    typedef logic [COL_W-1:0]  col_t;
    typedef logic [9:0]        cnt_t;

    localparam cnt_t H_VISIBLE    = 10'd640;
    localparam cnt_t H_SYNC_START = 10'd656;
    localparam cnt_t H_SYNC_END   = 10'd751;
    localparam cnt_t H_LAST       = 10'd799;
    localparam cnt_t V_VISIBLE    = 10'd480;
    localparam cnt_t V_SYNC_START = 10'd490;
    localparam cnt_t V_SYNC_END   = 10'd491;
    localparam cnt_t V_LAST       = 10'd524;

    localparam fb_addr_t FB_SIZE  = fb_addr_t'(FB_W * FB_H);
    localparam col_t     COL_LAST = col_t'(FB_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;

    function automatic fb_addr_t line_base(input cnt_t v);
        return fb_addr_t'(v >> SCALE_LOG2) * fb_addr_t'(FB_W);
    endfunction

endpackage

// File: rtl/vga_fb_fetch_arbiter_if.sv
// Host write handshake plus single-port framebuffer RAM bus.
interface vga_fb_fetch_arbiter_if;
    import vga_pkg::*;

    logic     host_valid;
    fb_addr_t host_addr;
    pixel_t   host_data;
    logic     host_ready;
    logic     host_drop;
    fb_addr_t mem_addr;
    logic     mem_re;
    logic     mem_we;
    pixel_t   mem_wdata;
    pixel_t   mem_rdata;

    modport slave (
        input  host_valid, host_addr, host_data, mem_rdata,
        output host_ready, host_drop, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output host_valid, host_addr, host_data, mem_rdata,
        input  host_ready, host_drop, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/vga_line_buffer.sv
// Ping-pong display line store: one write port, one registered read port.
module vga_line_buffer
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   we,
    input  logic   wr_sel,
    input  col_t   wr_idx,
    input  pixel_t wr_data,
    input  logic   rd_sel,
    input  col_t   rd_idx,
    output pixel_t rd_data
);

    pixel_t mem [2][FB_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_sel][wr_idx] <= wr_data;
        rd_data <= mem[rd_sel][rd_idx];
    end

endmodule

// File: rtl/vga_fb_fetch_arbiter.sv
// Shares the framebuffer RAM between blanking-time line prefetch and
// host pixel writes; serves the 4x-replicated image as 640x480 pixels.
module vga_fb_fetch_arbiter
    import vga_pkg::*;
(
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         pix_en,
    input  cnt_t                         h_count,
    input  cnt_t                         v_count,
    vga_fb_fetch_arbiter_if.slave        bus,
    output pixel_t                       pixel,
    output logic                         underrun
);

    fetch_state_e state, state_nx;
    cnt_t     next_v;
    logic     trigger, swap, in_vis, rdy;
    col_t     col, col_d, rd_idx;
    fb_addr_t base;
    logic     tgt, disp_sel, rd_d, pend, vis_q;
    logic [1:0] valid;
    pixel_t   rd_data;

    assign next_v  = (v_count == V_LAST) ? '0 : v_count + 10'd1;
    assign trigger = pix_en && h_count == H_VISIBLE && next_v < V_VISIBLE
                     && next_v[SCALE_LOG2-1:0] == '0;
    assign swap    = pix_en && h_count == H_LAST;
    assign in_vis  = h_count < H_VISIBLE && v_count < V_VISIBLE;
    assign rd_idx  = in_vis ? h_count[SCALE_LOG2 +: COL_W] : '0;

    always_comb begin
        state_nx      = state;
        rdy           = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.host_drop = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = arst_n && !trigger;
                if (trigger)
                    state_nx = FETCH;
            end
            FETCH: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = base + fb_addr_t'(col);
                if (col == COL_LAST)
                    state_nx = DRAIN;
            end
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Prefetch owns the RAM whenever rdy is low
        if (rdy && bus.host_valid) begin
            if (bus.host_addr < FB_SIZE) begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.host_addr;
                bus.mem_wdata = bus.host_data;
            end else begin
                bus.host_drop = 1'b1;
            end
        end
        bus.host_ready = rdy;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            col      <= '0;
            col_d    <= '0;
            base     <= '0;
            tgt      <= 1'b0;
            disp_sel <= 1'b0;
            rd_d     <= 1'b0;
            pend     <= 1'b0;
            valid    <= '0;
            underrun <= 1'b0;
            vis_q    <= 1'b0;
        end else begin
            state <= state_nx;
            col_d <= col;
            rd_d  <= (state == FETCH);
            vis_q <= in_vis && valid[disp_sel];
            if (state == IDLE && trigger) begin
                base           <= line_base(next_v);
                col            <= '0;
                tgt            <= ~disp_sel;
                valid[~disp_sel] <= 1'b0;
                pend           <= 1'b1;
            end else if (state == FETCH) begin
                col <= col + col_t'(1);
            end
            if (state == DRAIN)
                valid[tgt] <= 1'b1;
            // A late fetch still swaps; the display sees zeros until DRAIN
            if (swap && pend) begin
                disp_sel <= ~disp_sel;
                pend     <= 1'b0;
                if (state != IDLE)
                    underrun <= 1'b1;
            end
        end
    end

    vga_line_buffer u_lbuf (
        .clk     (clk),
        .we      (rd_d),
        .wr_sel  (tgt),
        .wr_idx  (col_d),
        .wr_data (bus.mem_rdata),
        .rd_sel  (disp_sel),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign pixel = vis_q ? rd_data : '0;

endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Directed bench: RAM model pre-filled with mem[a]=a[7:0], hand-derived
// pixel/address expectations per scenario.
module tb_vga_fb_fetch_arbiter;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       pix_en;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [7:0] pixel;
    logic       underrun;

    int vectors = 0;
    int errors  = 0;

    vga_fb_fetch_arbiter_if bus ();

    vga_fb_fetch_arbiter dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .pix_en   (pix_en),
        .h_count  (h_count),
        .v_count  (v_count),
        .bus      (bus),
        .pixel    (pixel),
        .underrun (underrun)
    );

    always #10 clk = ~clk;

    logic [7:0]  ram [32768];
    logic [14:0] re_log [$];
    int          we_cnt   = 0;
    int          both_cnt = 0;

    initial begin
        for (int i = 0; i < 32768; i++)
            ram[i] <= i[7:0];
    end

    always @(posedge clk) begin
        if (bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re)
            bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_re)
            re_log.push_back(bus.mem_addr);
        if (bus.mem_we)
            we_cnt <= we_cnt + 1;
        if (bus.mem_re && bus.mem_we)
            both_cnt <= both_cnt + 1;
    end

    task automatic test_reset;
        arst_n = 1'b0;
        pix_en = 1'b0;
        h_count = '0;
        v_count = '0;
        bus.host_valid = 1'b0;
        bus.host_addr  = '0;
        bus.host_data  = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (pixel !== 8'h00 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_pix pixel=%0h underrun=%0b want 0/0", pixel, underrun);
        end
        vectors++;
        if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd0) begin
            errors++;
            $display("FAIL reset_mem re=%0b we=%0b addr=%0d want 0/0/0",
                     bus.mem_re, bus.mem_we, bus.mem_addr);
        end
        vectors++;
        if (bus.host_ready !== 1'b0 || bus.host_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_host ready=%0b drop=%0b want 0/0",
                     bus.host_ready, bus.host_drop);
        end
        arst_n = 1'b1;
    endtask

    // row < 0: expect black line; frow < 0: expect no fetch
    task automatic run_line(input int v, input int row, input int frow);
        int n0, k, ex;
        bit ok;
        n0 = re_log.size();
        for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            v_count = 10'(v);
            h_count = 10'(h);
            pix_en  = 1'b0;
            @(negedge clk);
            ex = (row >= 0 && h < 640) ? ((row * 160 + h / 4) & 255) : 0;
            vectors++;
            if (pixel !== 8'(ex)) begin
                errors++;
                $display("FAIL pixel v=%0d h=%0d got %0d want %0d", v, h, pixel, ex);
            end
            pix_en = 1'b1;
        end
        k = re_log.size() - n0;
        vectors++;
        if (k !== ((frow >= 0) ? 160 : 0)) begin
            errors++;
            $display("FAIL fetch_count v=%0d got %0d want %0d", v, k,
                     (frow >= 0) ? 160 : 0);
        end
        if (frow >= 0 && k == 160) begin
            vectors++;
            if (re_log[n0] !== 15'(frow * 160)) begin
                errors++;
                $display("FAIL fetch_first v=%0d got %0d want %0d", v, re_log[n0], frow * 160);
            end
            ok = 1'b1;
            for (int i = 1; i < 160; i++)
                if (re_log[n0+i] !== 15'(re_log[n0+i-1] + 15'd1))
                    ok = 1'b0;
            vectors++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL fetch_seq v=%0d got non-contiguous want +1 steps", v);
            end
        end
    endtask

    task automatic test_host_block;
        int w0, lo;
        bit done;
        @(negedge clk);
        v_count = 10'd11;
        h_count = 10'd640;
        pix_en  = 1'b1;
        bus.host_valid = 1'b1;
        bus.host_addr  = 15'd5000;
        bus.host_data  = 8'hA5;
        w0 = we_cnt;
        #1;
        vectors++;
        if (bus.host_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_trigger got %0b want 0", bus.host_ready);
        end
        @(negedge clk);
        pix_en  = 1'b0;
        h_count = 10'd641;
        lo = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            #1;
            if (bus.host_ready === 1'b1) begin
                done = 1'b1;
                vectors++;
                if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0) begin
                    errors++;
                    $display("FAIL host_accept we=%0b re=%0b want 1/0", bus.mem_we, bus.mem_re);
                end
            end else begin
                lo++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        vectors++;
        if (!done || lo !== 161) begin
            errors++;
            $display("FAIL ready_low_clks got %0d (done=%0b) want 161", lo, done);
        end
        vectors++;
        if (we_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL host_writes got %0d want 1", we_cnt - w0);
        end
        vectors++;
        if (ram[5000] !== 8'hA5) begin
            errors++;
            $display("FAIL host_data got %0h want a5", ram[5000]);
        end
    endtask

    task automatic test_drop;
        @(negedge clk);
        h_count = 10'd100;
        bus.host_valid = 1'b1;
        bus.host_addr  = 15'd19200;
        bus.host_data  = 8'h3C;
        #1;
        vectors++;
        if (bus.host_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.host_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_oor ready=%0b we=%0b drop=%0b want 1/0/1",
                     bus.host_ready, bus.mem_we, bus.host_drop);
        end
        @(negedge clk);
        bus.host_addr = 15'd19199;
        bus.host_data = 8'h77;
        #1;
        vectors++;
        if (bus.host_drop !== 1'b0 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== 15'd19199 || bus.mem_wdata !== 8'h77) begin
            errors++;
            $display("FAIL last_addr drop=%0b we=%0b addr=%0d wdata=%0h want 0/1/19199/77",
                     bus.host_drop, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        #1;
        vectors++;
        if (bus.host_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse got %0b want 0", bus.host_drop);
        end
        vectors++;
        if (ram[19199] !== 8'h77 || ram[19200] !== 8'h00) begin
            errors++;
            $display("FAIL drop_ram got %0h/%0h want 77/00", ram[19199], ram[19200]);
        end
    endtask

    task automatic test_reset_mid_fetch;
        @(negedge clk);
        v_count = 10'd15;
        h_count = 10'd640;
        pix_en  = 1'b1;
        @(negedge clk);
        pix_en  = 1'b0;
        h_count = 10'd100;
        repeat (80) @(negedge clk);
        #1;
        vectors++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 15'd720) begin
            errors++;
            $display("FAIL mid_fetch re=%0b addr=%0d want 1/720", bus.mem_re, bus.mem_addr);
        end
        vectors++;
        if (pixel !== 8'd89) begin
            errors++;
            $display("FAIL pre_reset_pix got %0d want 89", pixel);
        end
        #2;
        arst_n = 1'b0;
        #1;
        vectors++;
        if (bus.mem_re !== 1'b0) begin
            errors++;
            $display("FAIL async_re got %0b want 0", bus.mem_re);
        end
        vectors++;
        if (pixel !== 8'h00 || dut.disp_sel !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL async_state pixel=%0d disp_sel=%0b underrun=%0b want 0/0/0",
                     pixel, dut.disp_sel, underrun);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_underrun;
        @(negedge clk);
        vectors++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clean got %0b want 0", underrun);
        end
        v_count = 10'd7;
        for (int h = 640; h < 800; h++) begin
            h_count = 10'(h);
            pix_en  = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set got %0b want 1", underrun);
        end
        pix_en  = 1'b0;
        h_count = 10'd0;
        v_count = 10'd8;
        repeat (20) @(negedge clk);
        vectors++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky got %0b want 1", underrun);
        end
        #2;
        arst_n = 1'b0;
        #1;
        vectors++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear got %0b want 0", underrun);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        run_line(524, -1, 0);
        run_line(0, 0, -1);
        run_line(1, 0, -1);
        run_line(2, 0, -1);
        run_line(3, 0, 1);
        run_line(4, 1, -1);
        run_line(5, 1, -1);
        run_line(6, 1, -1);
        run_line(7, 1, 2);
        test_host_block();
        test_drop();
        test_reset_mid_fetch();
        run_line(3, -1, 1);
        run_line(4, 1, -1);
        test_underrun();
        vectors++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL re_we_overlap got %0d clks want 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
